pc_fetch_queue: RTL and testbench
=================================

Name: pc_fetch_queue

Overview:
Parametrised instruction-fetch front end and next-generation IF stage. It generates the PC, issues one synchronous-ROM read per cycle and buffers {pc, inst} pairs in a DEPTH-entry FIFO. Decode drains the FIFO through a valid/ready handshake. Branch and flush redirects kill all buffered and in-flight fetches.

Parameters:
ADDR_W, 32, address and PC width
DATA_W, 32, instruction width
INIT_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 4, FIFO entries; power of 2, at least 2 (3 or more needed for full throughput)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush_valid  in  1  exception/flush redirect request
flush_addr  in  ADDR_W  flush target
branch_valid  in  1  branch redirect request
branch_addr  in  ADDR_W  branch target
rom_en  out  1  ROM read enable
rom_addr  out  ADDR_W  ROM read address
rom_we  out  DATA_W/8  ROM byte write enables; tied 0
rom_wdata  out  DATA_W  ROM write data; tied 0
rom_rdata  in  DATA_W  ROM data, valid the cycle after rom_en
out_valid  out  1  FIFO head valid
out_ready  in  1  decode accepts head
out_pc  out  ADDR_W  head PC
out_inst  out  DATA_W  head instruction

Behaviour:
- Clock clk; reset rst is synchronous, active-high.
- Reset state: fetch_pc=INIT_PC, count=0, req_q=0, FIFO storage=0.
- Reset outputs: rom_en=0, out_valid=0, out_pc=0, out_inst=0, rom_we=0, rom_wdata=0.
- Definitions:
  - redirect = flush_valid | branch_valid.
  - target = flush_addr when flush_valid, else branch_addr. Flush has priority over branch.
  - Bits [1:0] of target are forced to 0.
- Issue:
  - rom_en = !rst & !redirect & (count + req_q < DEPTH). This is combinational.
  - rom_addr = fetch_pc, always driven.
  - On issue: fetch_pc += 4 (wraps modulo 2^ADDR_W); req_q <= 1 and pc_q <= fetch_pc. Otherwise req_q <= 0.
- Response: when req_q=1, rom_rdata is valid that cycle. Push {pc_q, rom_rdata} at the clock edge unless redirect is high in that cycle.
- Pop: when out_valid & out_ready, the head advances at the edge.
  - Push and pop in the same cycle: count unchanged.
  - Pop is never blocked by a push.
- FIFO is first-word fall-through. out_valid = (count != 0). out_pc and out_inst are the head entry, driven from registers.
- Latency: request in cycle C; response in C+1; out_valid and the entry appear in C+2.
- Steady state with out_ready=1 and DEPTH>=3: one instruction per cycle, sequential PCs.
- Full: count + req_q = DEPTH gives rom_en=0 and fetch_pc holds. No entry is ever lost or duplicated.
- Redirect in cycle R:
  - rom_en=0 in R.
  - At the edge closing R: count<=0, head/tail pointers reset, req_q<=0, fetch_pc<=target. The pending response is discarded and any pop in R is ignored.
  - out_valid=0 in R+1. The first fetch of target issues in R+1 and appears at the output in R+3.
- Redirect held over multiple cycles: fetch_pc tracks the latest target; nothing is issued until redirect drops.
- rst overrides redirect. rst asserted mid-operation flushes everything in one edge; the first fetch is INIT_PC in the first cycle rst is low.
- No state machine beyond count/req_q/fetch_pc. Pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits.

Test Plan:
- Reset release with ROM returning 0x1000_0000+addr and out_ready=1 -> rom_en=1 with rom_addr=INIT_PC in cycle 0. out_valid rises in cycle 2 with out_pc=0x0, out_inst=0x1000_0000. Subsequently out_pc=0x4, 0x8, … every cycle.
- out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries buffered and rom_en=0 thereafter. On out_ready=1, PCs 0x0..0xC drain, then 0x10 follows with no gap or duplicate.
- branch_valid=1, branch_addr=0x0000_0203 for one cycle mid-stream -> rom_en=0 that cycle and out_valid=0 next cycle. rom_addr=0x200 issues next cycle; first output out_pc=0x200 two cycles later. No pre-branch PC appears afterwards.
- flush_valid (addr 0x80) and branch_valid (addr 0x40) in the same cycle -> subsequent stream starts at 0x80.
- fetch_pc=0xFFFF_FFFC with out_ready=1 -> next PC 0x0000_0000 (wrap).
- rst pulsed for one cycle while the FIFO holds 3 entries and a request is in flight -> out_valid=0 next cycle. The stream restarts at INIT_PC with no stale entry.

Source files
------------

// File: rtl/pc_fetch_queue.sv
// Instruction-fetch front end: PC generation, one synchronous-ROM read per
// cycle, and a first-word-fall-through FIFO of {pc, inst} pairs for decode.
// Branch/flush redirects discard all buffered and in-flight fetches.
module pc_fetch_queue #(
  parameter int unsigned       ADDR_W  = 32,
  parameter int unsigned       DATA_W  = 32,
  parameter logic [ADDR_W-1:0] INIT_PC = '0,
  parameter int unsigned       DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_valid,
  input  logic [ADDR_W-1:0]   flush_addr,
  input  logic                branch_valid,
  input  logic [ADDR_W-1:0]   branch_addr,
  output logic                rom_en,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic [DATA_W/8-1:0] rom_we,
  output logic [DATA_W-1:0]   rom_wdata,
  input  logic [DATA_W-1:0]   rom_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_pc,
  output logic [DATA_W-1:0]   out_inst
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned BE_W  = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_q;
  logic              req_q;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  entry_t            fifo_mem [DEPTH];

  logic              redirect;
  logic [ADDR_W-1:0] target_raw;
  logic [ADDR_W-1:0] target;
  logic [OCC_W-1:0]  occupancy;
  logic              room;
  logic              push;
  logic              pop;
  entry_t            head;

  // Redirect decode: flush wins over branch, target forced word-aligned
  always_comb begin
    redirect   = flush_valid | branch_valid;
    target_raw = flush_valid ? flush_addr : branch_addr;
    target     = {target_raw[ADDR_W-1:2], 2'b00};
  end

  // Issue only while buffered plus in-flight entries leave a free slot
  always_comb begin
    occupancy = OCC_W'(count) + OCC_W'(req_q);
    room      = occupancy < OCC_W'(DEPTH);
    rom_en    = ~rst & ~redirect & room;
    push      = req_q & ~redirect;
    pop       = out_valid & out_ready & ~redirect;
  end

  // ROM port: read address is the current fetch PC, write side unused
  always_comb begin
    rom_addr  = fetch_pc;
    rom_we    = BE_W'(0);
    rom_wdata = DATA_W'(0);
  end

  // FIFO head presented straight from storage (fall-through)
  always_comb begin
    head      = fifo_mem[rd_ptr];
    out_valid = (count != CNT_W'(0));
    out_pc    = head.pc;
    out_inst  = head.inst;
  end

  // PC, in-flight request and FIFO control state
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= INIT_PC;
      pc_q     <= '0;
      req_q    <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redirect) begin
      fetch_pc <= target;
      req_q    <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      req_q <= rom_en;
      if (rom_en) begin
        pc_q     <= fetch_pc;
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: cleared on reset, written with the returning ROM word
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (push) begin
      fifo_mem[wr_ptr] <= '{pc: pc_q, inst: rom_rdata};
    end
  end

endmodule

// File: tb/tb_pc_fetch_queue.sv
// Self-checking bench for pc_fetch_queue: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_pc_fetch_queue;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] INIT_PC = 32'h0000_0000;
  localparam logic [31:0] ROM_BASE = 32'h1000_0000;

  logic        clk;
  logic        rst;
  logic        flush_valid;
  logic [31:0] flush_addr;
  logic        branch_valid;
  logic [31:0] branch_addr;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [3:0]  rom_we;
  logic [31:0] rom_wdata;
  logic [31:0] rom_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  pc_fetch_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .INIT_PC(INIT_PC),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_valid (flush_valid),
    .flush_addr  (flush_addr),
    .branch_valid(branch_valid),
    .branch_addr (branch_addr),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_we      (rom_we),
    .rom_wdata   (rom_wdata),
    .rom_rdata   (rom_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: word at address A reads back as ROM_BASE + A
  initial rom_rdata = '0;
  always @(posedge clk) begin
    if (rom_en) rom_rdata <= ROM_BASE + rom_addr;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_req;
  logic [31:0] m_req_pc;

  bit          p_en;
  logic [31:0] p_addr;
  bit          p_ov;
  logic [31:0] p_pc;
  logic [31:0] p_inst;

  task automatic predict();
    int occ;
    occ    = mq.size() + (m_req ? 1 : 0);
    p_en   = !rst && !(flush_valid || branch_valid) && (occ < int'(DEPTH));
    p_addr = m_pc;
    p_ov   = (mq.size() != 0);
    p_pc   = p_ov ? mq[0].pc : 32'h0;
    p_inst = p_ov ? mq[0].inst : 32'h0;
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    ent_t        e;
    if (rst) begin
      mq.delete();
      m_req = 0;
      m_pc  = INIT_PC;
    end else if (flush_valid || branch_valid) begin
      tgt = flush_valid ? flush_addr : branch_addr;
      mq.delete();
      m_req = 0;
      m_pc  = tgt & 32'hFFFF_FFFC;
    end else begin
      if (p_ov && out_ready) void'(mq.pop_front());
      if (m_req) begin
        e.pc   = m_req_pc;
        e.inst = ROM_BASE + m_req_pc;
        mq.push_back(e);
      end
      m_req = p_en;
      if (p_en) begin
        m_req_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
    end
  endtask

  task automatic drive(input logic r, input logic fv, input logic [31:0] fa,
                       input logic bv, input logic [31:0] ba, input logic rdy);
    rst          = r;
    flush_valid  = fv;
    flush_addr   = fa;
    branch_valid = bv;
    branch_addr  = ba;
    out_ready    = rdy;
  endtask

  // First half of a cycle: predict and move to the sampling point
  task automatic half_a();
    predict();
    @(negedge clk);
  endtask

  // Second half: clock edge, advance model, step past the edge
  task automatic half_b();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic model_cmp();
    chk("rom_en", 32'(rom_en), 32'(p_en));
    chk("rom_addr", rom_addr, p_addr);
    chk("out_valid", 32'(out_valid), 32'(p_ov));
    if (p_ov) begin
      chk("out_pc", out_pc, p_pc);
      chk("out_inst", out_inst, p_inst);
    end
  endtask

  task automatic tick(input logic r, input logic fv, input logic [31:0] fa,
                      input logic bv, input logic [31:0] ba, input logic rdy);
    drive(r, fv, fa, bv, ba, rdy);
    half_a();
    model_cmp();
    half_b();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic        fv;
    logic [31:0] fa;
    logic        bv;
    logic [31:0] ba;
    logic        rdy;
    logic        e_en;
    logic [31:0] e_addr;
    logic        e_ov;
    logic        chk_data;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  initial begin
    logic [31:0] r_rnd;
    logic [31:0] b_rnd;

    //              rst   fv    fa           bv    ba           rdy   en    addr         ov    chkd  pc           inst
    vecs[0]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h0,       32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'h0,       32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0004, 1'b0, 1'b1, 32'h0,       32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0008, 1'b1, 1'b1, 32'h0,       32'h1000_0000};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_000C, 1'b1, 1'b1, 32'h4,       32'h1000_0004};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0203, 1'b1, 1'b0, 32'h0000_0010, 1'b1, 1'b1, 32'h8,     32'h1000_0008};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0,       32'h0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0204, 1'b0, 1'b0, 32'h0,       32'h0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0208, 1'b1, 1'b1, 32'h200,     32'h1000_0200};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_020C, 1'b1, 1'b1, 32'h204, 32'h1000_0204};
    vecs[10] = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 32'h0,       32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0084, 1'b0, 1'b0, 32'h0,       32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0088, 1'b1, 1'b1, 32'h80,      32'h1000_0080};

    // Preamble reset, not checked (outputs unknown before the first edge)
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    half_a();
    half_b();
    half_a();
    half_b();

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].fv, vecs[i].fa, vecs[i].bv, vecs[i].ba, vecs[i].rdy);
      half_a();
      chk($sformatf("vec%0d.rom_en", i), 32'(rom_en), 32'(vecs[i].e_en));
      chk($sformatf("vec%0d.rom_addr", i), rom_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      if (vecs[i].chk_data) begin
        chk($sformatf("vec%0d.out_pc", i), out_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d.out_inst", i), out_inst, vecs[i].e_inst);
      end
      if (i == 0) begin
        chk("reset.rom_we", 32'(rom_we), 32'h0);
        chk("reset.rom_wdata", rom_wdata, 32'h0);
      end
      half_b();
    end

    // Backpressure: stall decode long enough to fill, then drain
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    half_a();
    chk("full.rom_en", 32'(rom_en), 32'h0);
    chk("full.out_valid", 32'(out_valid), 32'h1);
    model_cmp();
    half_b();
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    // PC wrap through the top of the address space
    tick(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFA, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    half_a();
    chk("wrap.rom_addr", rom_addr, 32'h0000_0000);
    model_cmp();
    half_b();
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    // Reset mid-stream with three entries buffered and one in flight
    tick(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0400, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    half_a();
    chk("rst_mid.out_valid", 32'(out_valid), 32'h0);
    chk("rst_mid.out_pc", out_pc, 32'h0);
    chk("rst_mid.out_inst", out_inst, 32'h0);
    chk("rst_mid.rom_en", 32'(rom_en), 32'h1);
    chk("rst_mid.rom_addr", rom_addr, INIT_PC);
    half_b();
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r_rnd = $urandom;
      b_rnd = $urandom;
      if (r_rnd[7:4] == 4'hF && r_rnd[3]) b_rnd = 32'hFFFF_FFF0 | (b_rnd & 32'hF);
      tick(r_rnd[15:8] == 8'h00,
           r_rnd[20:16] == 5'h00, $urandom,
           r_rnd[24:21] == 4'h0, b_rnd,
           r_rnd[27:26] != 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
